// File: rtl/relu_nn_seq_pkg.sv
// -----------------------------------------------------------------------------
// relu_nn_seq_pkg
// Shared definitions for the time-multiplexed 2-2-1 ReLU network sequencer:
// weight-bank register indices, FSM state encoding, phase-counter width and a
// small address-range helper used by the weight bank.
// -----------------------------------------------------------------------------
package relu_nn_seq_pkg;

    // Weight bank register indices
    localparam logic [3:0] H1_W1    = 4'd0;
    localparam logic [3:0] H1_W2    = 4'd1;
    localparam logic [3:0] H1_BIAS  = 4'd2;
    localparam logic [3:0] H2_W1    = 4'd3;
    localparam logic [3:0] H2_W2    = 4'd4;
    localparam logic [3:0] H2_BIAS  = 4'd5;
    localparam logic [3:0] OUT_W1   = 4'd6;
    localparam logic [3:0] OUT_W2   = 4'd7;
    localparam logic [3:0] OUT_BIAS = 4'd8;
    localparam int         NUM_REGS = 9;

    // Sequencer states
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PH_H1  = 3'd1;
    localparam logic [2:0] PH_H2  = 3'd2;
    localparam logic [2:0] PH_OUT = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    // Phase counter width: covers NEURON_LAT up to 7
    localparam int PH_CNT_W = 3;

    // True when a config address names an existing weight register
    function automatic logic addr_in_range(input logic [3:0] addr);
        return (addr <= OUT_BIAS);
    endfunction

endpackage

// File: rtl/relu_neuron.sv
// -----------------------------------------------------------------------------
// relu_neuron
// Single fixed-point ReLU neuron: y = relu(((in1*w1 + in2*w2) >>> FRAC) + bias),
// saturated to the largest positive WIDTH-bit value. The result appears LAT
// clock edges after an operand change (LAT = 0 gives a combinational path).
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   in1_i, in2_i, w1_i, w2_i, bias_i signed operands
//   result_o                         neuron output
// -----------------------------------------------------------------------------
module relu_neuron #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    input  logic [WIDTH-1:0] w1_i,
    input  logic [WIDTH-1:0] w2_i,
    input  logic [WIDTH-1:0] bias_i,
    output logic [WIDTH-1:0] result_o
);

    logic signed [2*WIDTH-1:0] p1_s, p2_s;
    logic signed [2*WIDTH:0]   acc_s, sum_s;
    logic        [WIDTH-1:0]   y_s;

    // Multiply-accumulate, rescale, bias, then ReLU with positive saturation
    always_comb begin
        p1_s  = $signed(in1_i) * $signed(w1_i);
        p2_s  = $signed(in2_i) * $signed(w2_i);
        acc_s = $signed({p1_s[2*WIDTH-1], p1_s}) + $signed({p2_s[2*WIDTH-1], p2_s});
        sum_s = (acc_s >>> FRAC) + $signed({{(WIDTH+1){bias_i[WIDTH-1]}}, bias_i});
        if (sum_s[2*WIDTH]) begin
            y_s = '0;
        end else if (|sum_s[2*WIDTH-1:WIDTH-1]) begin
            y_s = {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            y_s = sum_s[WIDTH-1:0];
        end
    end

    if (LAT == 0) begin : g_comb
        assign result_o = y_s;
    end else begin : g_pipe
        logic [LAT-1:0][WIDTH-1:0] pipe_q;

        // Result delay line
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pipe_q <= '0;
            end else begin
                pipe_q[0] <= y_s;
                for (int i = 1; i < LAT; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign result_o = pipe_q[LAT-1];
    end

endmodule

// File: rtl/relu_nn_wbank.sv
// -----------------------------------------------------------------------------
// relu_nn_wbank
// Nine-entry weight/bias register bank for relu_nn_seq.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (bank clears to 0)
//   idle_i          sequencer is idle; writes are only accepted then
//   cfg_we          write strobe
//   cfg_addr        register index 0..8
//   cfg_wdata       write data
//   cfg_ready       a write would be accepted this cycle
//   cfg_err         registered one-cycle pulse after a rejected write
//   rd_o            all nine registers in parallel, write-through view
// rd_o presents the value the bank will hold after the current edge, so an
// operand register loaded on the same edge as a write sees the new weight.
// -----------------------------------------------------------------------------
module relu_nn_wbank
    import relu_nn_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               idle_i,
    input  logic                               cfg_we,
    input  logic [3:0]                         cfg_addr,
    input  logic [WIDTH-1:0]                   cfg_wdata,
    output logic                               cfg_ready,
    output logic                               cfg_err,
    output logic [NUM_REGS-1:0][WIDTH-1:0]     rd_o
);

    logic [NUM_REGS-1:0][WIDTH-1:0] regs_q, regs_d;
    logic                           err_q, err_d;
    logic                           wr_s;

    // Write decode, error detection and next-state of the bank
    always_comb begin
        wr_s  = cfg_we & idle_i & addr_in_range(cfg_addr);
        err_d = cfg_we & ~wr_s;
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_s && (cfg_addr == 4'(i))) begin
                regs_d[i] = cfg_wdata;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Bank and error-pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            err_q  <= err_d;
        end
    end

    assign cfg_ready = idle_i;
    assign cfg_err   = err_q;
    assign rd_o      = regs_d;

endmodule

// File: rtl/relu_nn_seq.sv
// -----------------------------------------------------------------------------
// relu_nn_seq
// Time-multiplexed sequencer for a 2-2-1 ReLU XOR network. One external
// relu_neuron evaluates hidden neuron 1, hidden neuron 2 and the output neuron
// in turn; this block holds the weights, sequences the phases and captures the
// neuron's results.
// Parameters: WIDTH (data width), FRAC (fraction bits, interface only),
//             NEURON_LAT (edges from operand change to valid n_result, 0..7).
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_x1/in_x2 input pair handshake
//   out_valid/out_ready/out_y     result handshake, out_y held while in DONE
//   cfg_we/cfg_addr/cfg_wdata     weight write port (accepted only when idle)
//   cfg_ready/cfg_err             write acceptance / rejected-write pulse
//   n_in1,n_in2,n_w1,n_w2,n_bias  registered operands to the shared neuron
//   n_result                      shared neuron result
//   busy                          not idle
//   inf_count                     completed-inference counter
// Build option: RELU_NN_SEQ_CNT_EN enables the inf_count counter; when it is
// not defined inf_count is tied to 0.
// -----------------------------------------------------------------------------
module relu_nn_seq
    import relu_nn_seq_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 8,
    parameter int NEURON_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x1,
    input  logic [WIDTH-1:0] in_x2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_wdata,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [WIDTH-1:0] n_in1,
    output logic [WIDTH-1:0] n_in2,
    output logic [WIDTH-1:0] n_w1,
    output logic [WIDTH-1:0] n_w2,
    output logic [WIDTH-1:0] n_bias,
    input  logic [WIDTH-1:0] n_result,
    output logic             busy,
    output logic [15:0]      inf_count
);

    // Elaboration-time parameter sanity
    if ((NEURON_LAT < 0) || (NEURON_LAT > 7) || (FRAC < 0) || (FRAC >= WIDTH)) begin : g_bad_param
        $error("relu_nn_seq: illegal NEURON_LAT or FRAC");
    end

    localparam logic [PH_CNT_W-1:0] LAST_CNT = 3'(NEURON_LAT);

    logic [2:0]              state_q, state_d;
    logic [PH_CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]        x1_q, x1_d, x2_q, x2_d;
    logic [WIDTH-1:0]        h1_q, h1_d, h2_q, h2_d;
    logic [WIDTH-1:0]        y_q, y_d;
    logic [WIDTH-1:0]        n_in1_q, n_in1_d, n_in2_q, n_in2_d;
    logic [WIDTH-1:0]        n_w1_q, n_w1_d, n_w2_q, n_w2_d;
    logic [WIDTH-1:0]        n_bias_q, n_bias_d;
    logic                    in_ready_q, busy_q, out_valid_q;
    logic                    last_s;
    logic [NUM_REGS-1:0][WIDTH-1:0] wt_s;

    relu_nn_wbank #(.WIDTH(WIDTH)) u_wbank (
        .clk       (clk),
        .rst       (rst),
        .idle_i    (in_ready_q),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .rd_o      (wt_s)
    );

    // FSM, phase counter and result captures
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        h1_d    = h1_q;
        h2_d    = h2_q;
        y_d     = y_q;
        last_s  = (cnt_q == LAST_CNT);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x1_d    = in_x1;
                    x2_d    = in_x2;
                    cnt_d   = '0;
                    state_d = PH_H1;
                end else begin
                    state_d = IDLE;
                end
            end
            PH_H1: begin
                if (last_s) begin
                    h1_d    = n_result;
                    cnt_d   = '0;
                    state_d = PH_H2;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            PH_H2: begin
                if (last_s) begin
                    h2_d    = n_result;
                    cnt_d   = '0;
                    state_d = PH_OUT;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            PH_OUT: begin
                if (last_s) begin
                    y_d     = n_result;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Operand selection for the phase being entered. Uses the next-state
    // values so operands switch on the same edge as the phase, including the
    // hidden result captured on that edge.
    always_comb begin
        n_in1_d  = n_in1_q;
        n_in2_d  = n_in2_q;
        n_w1_d   = n_w1_q;
        n_w2_d   = n_w2_q;
        n_bias_d = n_bias_q;
        case (state_d)
            PH_H1: begin
                n_in1_d  = x1_d;
                n_in2_d  = x2_d;
                n_w1_d   = wt_s[H1_W1];
                n_w2_d   = wt_s[H1_W2];
                n_bias_d = wt_s[H1_BIAS];
            end
            PH_H2: begin
                n_in1_d  = x1_d;
                n_in2_d  = x2_d;
                n_w1_d   = wt_s[H2_W1];
                n_w2_d   = wt_s[H2_W2];
                n_bias_d = wt_s[H2_BIAS];
            end
            PH_OUT: begin
                n_in1_d  = h1_d;
                n_in2_d  = h2_d;
                n_w1_d   = wt_s[OUT_W1];
                n_w2_d   = wt_s[OUT_W2];
                n_bias_d = wt_s[OUT_BIAS];
            end
            default: begin
                n_in1_d  = n_in1_q;
                n_in2_d  = n_in2_q;
                n_w1_d   = n_w1_q;
                n_w2_d   = n_w2_q;
                n_bias_d = n_bias_q;
            end
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            h1_q        <= '0;
            h2_q        <= '0;
            y_q         <= '0;
            n_in1_q     <= '0;
            n_in2_q     <= '0;
            n_w1_q      <= '0;
            n_w2_q      <= '0;
            n_bias_q    <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            h1_q        <= h1_d;
            h2_q        <= h2_d;
            y_q         <= y_d;
            n_in1_q     <= n_in1_d;
            n_in2_q     <= n_in2_d;
            n_w1_q      <= n_w1_d;
            n_w2_q      <= n_w2_d;
            n_bias_q    <= n_bias_d;
            in_ready_q  <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

`ifdef RELU_NN_SEQ_CNT_EN
    logic [15:0] inf_cnt_q, inf_cnt_d;

    // Count completed result handshakes, wrapping naturally at 16 bits
    always_comb begin
        if (out_valid_q && out_ready) begin
            inf_cnt_d = inf_cnt_q + 16'd1;
        end else begin
            inf_cnt_d = inf_cnt_q;
        end
    end

    // Inference counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inf_cnt_q <= 16'd0;
        end else begin
            inf_cnt_q <= inf_cnt_d;
        end
    end

    assign inf_count = inf_cnt_q;
`else
    assign inf_count = 16'd0;
`endif

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_y     = y_q;
    assign n_in1     = n_in1_q;
    assign n_in2     = n_in2_q;
    assign n_w1      = n_w1_q;
    assign n_w2      = n_w2_q;
    assign n_bias    = n_bias_q;

endmodule
